// File: rtl/tl_left_phase_ctrl_pkg.sv
// Shared state encoding and lamp codes for the left-turn phase sequencer.
package tl_left_phase_ctrl_pkg;

    // 3-bit state codes; bit 0 set marks a yellow phase, bit 2 selects street B.
    typedef enum logic [2:0] {
        S0 = 3'b000,  // A green
        S1 = 3'b001,  // A yellow
        S2 = 3'b010,  // A left
        S3 = 3'b011,  // A left yellow
        S4 = 3'b100,  // B green
        S5 = 3'b101,  // B yellow
        S6 = 3'b110,  // B left
        S7 = 3'b111   // B left yellow
    } state_e;

    localparam logic [1:0] GRN = 2'b00;
    localparam logic [1:0] YEL = 2'b01;
    localparam logic [1:0] LFT = 2'b10;
    localparam logic [1:0] RED = 2'b11;

endpackage

// File: rtl/o_logic.sv
// Lamp decoder: pure combinational map from state code to street A/B lamps.
module o_logic
    import tl_left_phase_ctrl_pkg::*;
(
    input  logic [2:0] q,
    output logic [1:0] La,
    output logic [1:0] Lb
);

    // Decode state code into the two lamp codes.
    always_comb begin
        La = RED;
        Lb = RED;
        unique case (q)
            3'b000:  begin La = GRN; Lb = RED; end
            3'b001:  begin La = YEL; Lb = RED; end
            3'b010:  begin La = LFT; Lb = RED; end
            3'b011:  begin La = YEL; Lb = RED; end
            3'b100:  begin La = RED; Lb = GRN; end
            3'b101:  begin La = RED; Lb = YEL; end
            3'b110:  begin La = RED; Lb = LFT; end
            3'b111:  begin La = RED; Lb = YEL; end
            default: begin La = RED; Lb = RED; end
        endcase
    end

endmodule

// File: rtl/tl_left_phase_ctrl_dwell_cnt.sv
// Dwell counter: synchronous clear, otherwise saturating increment.
module tl_left_phase_ctrl_dwell_cnt #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Next count: clear wins, then increment until all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tl_left_phase_ctrl.sv
// Eight-state Moore phase sequencer with min/max green dwell and protected lefts.
module tl_left_phase_ctrl
    import tl_left_phase_ctrl_pkg::*;
#(
    parameter int unsigned YEL_CYC = 3,
    parameter int unsigned MIN_GRN = 4,
    parameter int unsigned MAX_GRN = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       Tal,
    input  logic       Tbl,
    output logic [2:0] q,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic       phase_chg
);

    localparam logic [CNT_W-1:0] YelLast = CNT_W'(YEL_CYC - 1);
    localparam logic [CNT_W-1:0] MinLast = CNT_W'(MIN_GRN - 1);
    localparam logic [CNT_W-1:0] MaxLast = CNT_W'(MAX_GRN - 1);

    state_e           state_d, state_q;
    logic             phase_chg_q;
    logic             demand;
    logic             exit_now;
    logic [CNT_W-1:0] cnt;

    tl_left_phase_ctrl_dwell_cnt #(
        .CNT_W(CNT_W)
    ) u_dwell_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (exit_now),
        .cnt  (cnt)
    );

    // Exit decision and next state; sensors matter only in the exit-decision cycle.
    always_comb begin
        demand   = 1'b0;
        exit_now = 1'b0;
        state_d  = state_q;
        unique case (state_q)
            S0:      demand = Ta;
            S2:      demand = Tal;
            S4:      demand = Tb;
            S6:      demand = Tbl;
            default: demand = 1'b0;
        endcase
        if (state_q[0]) begin
            exit_now = (cnt == YelLast);
        end else begin
            exit_now = (cnt >= MinLast) && (!demand || (cnt >= MaxLast));
        end
        if (exit_now) begin
            unique case (state_q)
                S0:      state_d = S1;
                S1:      state_d = Tal ? S2 : S4;
                S2:      state_d = S3;
                S3:      state_d = S4;
                S4:      state_d = S5;
                S5:      state_d = Tbl ? S6 : S0;
                S6:      state_d = S7;
                S7:      state_d = S0;
                default: state_d = S0;
            endcase
        end
    end

    // State and phase-change pulse; reset re-enters S0 as a fresh phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S0;
            phase_chg_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_chg_q <= exit_now;
        end
    end

    o_logic u_o_logic (
        .q (state_q),
        .La(La),
        .Lb(Lb)
    );

    assign q         = state_q;
    assign phase_chg = phase_chg_q;

endmodule

// File: tb/tb_tl_left_phase_ctrl.sv
// Directed table-driven bench for the left-turn phase sequencer.
module tb_tl_left_phase_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       Ta, Tb, Tal, Tbl;
    logic [2:0] q;
    logic [1:0] La, Lb;
    logic       phase_chg;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       ta;
        logic       tb;
        logic       tal;
        logic       tbl;
        logic       rst;
        logic [2:0] st;
        logic       first;
        int         dur;
    } vec_t;

    vec_t vecs[$];

    tl_left_phase_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .Ta       (Ta),
        .Tb       (Tb),
        .Tal      (Tal),
        .Tbl      (Tbl),
        .q        (q),
        .La       (La),
        .Lb       (Lb),
        .phase_chg(phase_chg)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] dem, input logic rst, input logic [2:0] st,
                                input logic first, input int dur);
        vec_t v;
        v.ta    = dem[3];
        v.tb    = dem[2];
        v.tal   = dem[1];
        v.tbl   = dem[0];
        v.rst   = rst;
        v.st    = st;
        v.first = first;
        v.dur   = dur;
        return v;
    endfunction

    function automatic logic [3:0] lamps(input logic [2:0] st);
        case (st)
            3'd0:    return 4'b00_11;
            3'd1:    return 4'b01_11;
            3'd2:    return 4'b10_11;
            3'd3:    return 4'b01_11;
            3'd4:    return 4'b11_00;
            3'd5:    return 4'b11_01;
            3'd6:    return 4'b11_10;
            default: return 4'b11_01;
        endcase
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp_v);
    endtask

    // Hold the row's inputs for dur cycles, checking outputs each cycle before the edge.
    task automatic apply(input vec_t v);
        logic [3:0] lp;
        for (int c = 0; c < v.dur; c++) begin
            Ta    = v.ta;
            Tb    = v.tb;
            Tal   = v.tal;
            Tbl   = v.tbl;
            reset = v.rst;
            lp    = lamps(v.st);
            check("q", {1'b0, q}, {1'b0, v.st});
            check("La", {2'b00, La}, {2'b00, lp[3:2]});
            check("Lb", {2'b00, Lb}, {2'b00, lp[1:0]});
            check("phase_chg", {3'b000, phase_chg}, {3'b000, (c == 0) ? v.first : 1'b0});
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        // Idle: S0 4, S1 3, S4 4, S5 3
        vecs.push_back(mk(4'b0000, 1'b0, 3'd0, 1'b1, 4));
        vecs.push_back(mk(4'b0000, 1'b0, 3'd1, 1'b1, 3));
        vecs.push_back(mk(4'b0000, 1'b0, 3'd4, 1'b1, 4));
        vecs.push_back(mk(4'b0000, 1'b0, 3'd5, 1'b1, 3));
        // Ta held: S0 capped at 16
        vecs.push_back(mk(4'b1000, 1'b0, 3'd0, 1'b1, 16));
        vecs.push_back(mk(4'b0000, 1'b0, 3'd1, 1'b1, 3));
        vecs.push_back(mk(4'b0000, 1'b0, 3'd4, 1'b1, 4));
        vecs.push_back(mk(4'b0000, 1'b0, 3'd5, 1'b1, 3));
        // Tal present at S1 exit: A left phase taken
        vecs.push_back(mk(4'b0010, 1'b0, 3'd0, 1'b1, 4));
        vecs.push_back(mk(4'b0010, 1'b0, 3'd1, 1'b1, 3));
        vecs.push_back(mk(4'b0000, 1'b0, 3'd2, 1'b1, 4));
        vecs.push_back(mk(4'b0000, 1'b0, 3'd3, 1'b1, 3));
        vecs.push_back(mk(4'b0000, 1'b0, 3'd4, 1'b1, 4));
        vecs.push_back(mk(4'b0000, 1'b0, 3'd5, 1'b1, 3));
        // Tb and Tbl held: both B phases capped
        vecs.push_back(mk(4'b0101, 1'b0, 3'd0, 1'b1, 4));
        vecs.push_back(mk(4'b0101, 1'b0, 3'd1, 1'b1, 3));
        vecs.push_back(mk(4'b0101, 1'b0, 3'd4, 1'b1, 16));
        vecs.push_back(mk(4'b0101, 1'b0, 3'd5, 1'b1, 3));
        vecs.push_back(mk(4'b0101, 1'b0, 3'd6, 1'b1, 16));
        vecs.push_back(mk(4'b0101, 1'b0, 3'd7, 1'b1, 3));
        // Ta high through cnt=7, sampled low at cnt=8: S0 lasts 9 cycles
        vecs.push_back(mk(4'b1000, 1'b0, 3'd0, 1'b1, 8));
        vecs.push_back(mk(4'b0000, 1'b0, 3'd0, 1'b0, 1));
        vecs.push_back(mk(4'b0000, 1'b0, 3'd1, 1'b1, 3));
        vecs.push_back(mk(4'b0000, 1'b0, 3'd4, 1'b1, 4));
        vecs.push_back(mk(4'b0000, 1'b0, 3'd5, 1'b1, 3));

        Ta = 1'b0; Tb = 1'b0; Tal = 1'b0; Tbl = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Reach S6 with Tbl, then reset during the cnt=5 cycle
        apply(mk(4'b0001, 1'b0, 3'd0, 1'b1, 4));
        apply(mk(4'b0001, 1'b0, 3'd1, 1'b1, 3));
        apply(mk(4'b0001, 1'b0, 3'd4, 1'b1, 4));
        apply(mk(4'b0001, 1'b0, 3'd5, 1'b1, 3));
        apply(mk(4'b0001, 1'b0, 3'd6, 1'b1, 5));
        apply(mk(4'b0001, 1'b1, 3'd6, 1'b0, 1));
        // Back in S0 with a cleared dwell: minimum dwell again, then normal sequencing
        apply(mk(4'b0000, 1'b0, 3'd0, 1'b1, 4));
        apply(mk(4'b0000, 1'b0, 3'd1, 1'b1, 3));
        apply(mk(4'b0000, 1'b0, 3'd4, 1'b1, 4));
        apply(mk(4'b0000, 1'b0, 3'd5, 1'b1, 3));
        apply(mk(4'b0000, 1'b0, 3'd0, 1'b1, 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tl_left_phase_ctrl.md
# tl_left_phase_ctrl

Phase sequencer for the four-way intersection with protected left turns. Eight-state Moore FSM with a dwell timer; drives the 3-bit state code (q2,q1,q0) into the existing `o_logic` light decoder. Sits between the road sensors and the lamp drivers. Min/max green limits prevent both flicker and starvation.

## Interface
- `YEL_CYC`, default 3: yellow dwell, in clock cycles (≥1).
- `MIN_GRN`, default 4: minimum green or left dwell, in cycles (≥1).
- `MAX_GRN`, default 16: maximum green or left dwell while demand persists (> `MIN_GRN`).
- `CNT_W`, default 5: dwell counter width. Must satisfy 2^`CNT_W` > `MAX_GRN`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `Ta` in 1: through-traffic demand on street A.
- `Tb` in 1: through-traffic demand on street B.
- `Tal` in 1: left-turn demand on street A.
- `Tbl` in 1: left-turn demand on street B.
- `q` out 3: current state code {q2,q1,q0}.
- `La` out 2: street A lamp, {La1,La0}.
- `Lb` out 2: street B lamp, {Lb1,Lb0}.
- `phase_chg` out 1: one-cycle pulse in the first cycle of each new state.

## Operation
- Lamp code: 00 = green, 01 = yellow, 10 = left arrow, 11 = red.
- States, with code and (La, Lb):
  - S0 000: A green (00, 11)
  - S1 001: A yellow (01, 11)
  - S2 010: A left (10, 11)
  - S3 011: A left yellow (01, 11)
  - S4 100: B green (11, 00)
  - S5 101: B yellow (11, 01)
  - S6 110: B left (11, 10)
  - S7 111: B left yellow (11, 01)
- `cnt`: dwell counter. Cleared to 0 on every state transition; otherwise increments, saturating at 2^`CNT_W`−1.
- Green/left exit rule, with D = that state's demand input (S0: `Ta`, S2: `Tal`, S4: `Tb`, S6: `Tbl`):
  - leave when `cnt` ≥ `MIN_GRN`−1 AND (D = 0 OR `cnt` ≥ `MAX_GRN`−1).
- Yellow exit rule: leave when `cnt` = `YEL_CYC`−1.
- Transitions:
  - S0→S1.
  - S1→S2 if `Tal` = 1 at the exit cycle, else S1→S4 (left phase skipped).
  - S2→S3, S3→S4, S4→S5.
  - S5→S6 if `Tbl` = 1, else S5→S0.
  - S6→S7, S7→S0.
- Sensor inputs are sampled only in exit-decision cycles; demand changes mid-dwell have no other effect.
- `La`/`Lb` are a pure decode of the state register through `o_logic`. No extra register.

## Timing
- Reset values: state S0, `q` = 000, `cnt` = 0, `La` = 00, `Lb` = 11, `phase_chg` = 1 in the first cycle after reset deasserts (S0 treated as newly entered).
- An exit condition true in cycle n gives the new state in cycle n+1, with `cnt` = 0 and `phase_chg` = 1 in that cycle.
- Dwell lengths:
  - Yellow: exactly `YEL_CYC` cycles.
  - Green/left with demand held low: exactly `MIN_GRN` cycles.
  - Green/left with demand held high: exactly `MAX_GRN` cycles.
- Demand dropping at `cnt` = k, with `MIN_GRN`−1 ≤ k < `MAX_GRN`−1: exit decided in the cycle that samples the low level.
- Conflicting demands on both streets: ignored except by the exit rules. Fairness comes from the `MAX_GRN` cap.
- `reset` asserted in any state, at any `cnt`: the next edge forces S0, `cnt` = 0, with no yellow. Reset has priority over every transition.
- Illegal codes cannot occur with a 3-bit state. The `default` branch returns to S0 regardless.

## Structure
- Shared package/header holds:
  - state localparams S0..S7 with the 3-bit codes above;
  - lamp code constants GRN/YEL/LFT/RED.
- Sub-modules:
  - instantiate the existing `o_logic` as the output decoder;
  - optional `dwell_cnt` (clear, saturating increment) as the only new sub-module.
- The rest is the next-state logic plus the state and `cnt` registers.

## Test plan
- Reset with `Ta` = `Tb` = `Tal` = `Tbl` = 0, defaults → S0 for 4 cycles, S1 for 3, S4 for 4, S5 for 3, back to S0. Full cycle 14 cycles; `La` sequence 00,01,11,11.
- `Ta` = 1 held → S0 lasts exactly 16 cycles, then S1; `phase_chg` pulses at cycle 16.
- `Tal` = 1 with `Ta` = 0 → S0(4), S1(3), S2(4), S3(3), S4; in S2 `La` = 10 and `Lb` = 11.
- `Tb` = `Tbl` = 1 held → S4 16 cycles, S5 3, S6 16, S7 3, then S0. No state outside the legal sequence.
- `Ta` = 1 then dropped after S0 `cnt` = 7 → S0 exits at `cnt` = 7 or 8 per the sampling rule. Check exact cycle: `Ta` sampled low at `cnt` = 8 → S1 the next cycle.
- Assert `reset` for one cycle while in S6 at `cnt` = 5 → next cycle `q` = 000, `La` = 00, `Lb` = 11, `cnt` = 0. Normal sequencing resumes.
